// File: rtl/piso_serializer.sv
// Double-buffered parallel-in/serial-out stage: WIDTH-bit words in over valid/ready, MSB first out.
// Optional macro PISO_PARITY_EN appends an even-parity bit after each word.
module piso_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("piso_serializer: WIDTH must be in 2..32");
    end

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             word_done_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic             transfer;
    logic             last_bit;
    logic             load_from_hold;
    logic             load_direct;
    logic             hold_wr;
    logic [WIDTH-1:0] load_word;

    always_comb begin
        transfer       = din_valid && din_ready;
        last_bit       = (state_q == StShift) && (cnt_q == LAST_CNT);
        load_from_hold = last_bit && hold_full_q;
        load_direct    = ((state_q == StIdle) && transfer) ||
                         (last_bit && !hold_full_q && transfer);
        // A transfer not consumed by the shifter this edge always lands in hold.
        hold_wr        = transfer && !load_direct;
        load_word      = load_from_hold ? hold_q : din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            if (load_from_hold || load_direct) begin
                state_q      <= StShift;
                cnt_q        <= '0;
                sout_q       <= load_word[WIDTH-1];
                shreg_q      <= {load_word[WIDTH-2:0], 1'b0};
                sout_valid_q <= 1'b1;
                word_done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
                par_q        <= ^load_word;
`endif
            end else if (last_bit) begin
                state_q      <= StIdle;
                cnt_q        <= '0;
                sout_q       <= IDLE_BIT;
                sout_valid_q <= 1'b0;
                word_done_q  <= 1'b0;
            end else if (state_q == StShift) begin
                cnt_q       <= cnt_q + CNT_W'(1);
                shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
                word_done_q <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
`ifdef PISO_PARITY_EN
                sout_q      <= (cnt_q == CNT_W'(WIDTH - 1)) ? par_q : shreg_q[WIDTH-1];
`else
                sout_q      <= shreg_q[WIDTH-1];
`endif
            end

            if (hold_wr) begin
                hold_q      <= din;
                hold_full_q <= 1'b1;
            end else if (load_from_hold) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    assign din_ready  = !hold_full_q;
    assign busy       = (state_q == StShift) || hold_full_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign word_done  = word_done_q;

endmodule
